// File: rtl/riscv_arb_pkg.sv
// riscv_arb_pkg: shared types for the fetch/data memory arbiter.
// FSM states, transaction owner and the fetch alignment mask.
package riscv_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  localparam logic [31:0] FETCH_ALIGN = 32'hFFFF_FFFC;

  function automatic logic [31:0] fetch_addr(input logic [31:0] pc);
    return pc & FETCH_ALIGN;
  endfunction

endpackage

// File: rtl/riscv_arb_prio.sv
// riscv_arb_prio: grant decision for the shared memory port.
// Data wins unless a fetch has waited through STARVE_LIMIT data grants.
module riscv_arb_prio #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic i_req,
  input  logic d_req,
  input  logic cmo,
  output logic gnt_i,
  output logic gnt_d,
  output logic gnt_cmo
);

  localparam int unsigned SW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  logic [SW-1:0] streak;
  logic          starve;
  logic          win_d;
  logic          win_i;
  logic          win_c;

  assign starve = i_req && (streak >= LIM);
  assign win_d  = d_req && !starve;
  assign win_i  = i_req && !win_d;
  assign win_c  = cmo && !d_req && !i_req;

  // Grants only happen while the port is free.
  always_comb begin
    gnt_d   = 1'b0;
    gnt_i   = 1'b0;
    gnt_cmo = 1'b0;
    if (idle) begin
      gnt_d   = win_d;
      gnt_i   = win_i;
      gnt_cmo = win_c;
    end
  end

  // Count data grants made while a fetch waits; saturate at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (gnt_i || (idle && !i_req)) begin
      streak <= '0;
    end else if (gnt_d && (streak < LIM)) begin
      streak <= streak + SW'(1);
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one memory port between core fetch and data.
// One transaction in flight; cache maintenance is acked locally.
module riscv_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TAG_W        = 11,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mem_i_rd_i,
  input  logic [31:0]      mem_i_pc_i,
  output logic             mem_i_accept_o,
  output logic             mem_i_valid_o,
  output logic             mem_i_error_o,
  output logic [31:0]      mem_i_inst_o,
  input  logic [31:0]      mem_d_addr_i,
  input  logic [31:0]      mem_d_data_wr_i,
  input  logic             mem_d_rd_i,
  input  logic [3:0]       mem_d_wr_i,
  input  logic [TAG_W-1:0] mem_d_req_tag_i,
  input  logic             mem_d_invalidate_i,
  input  logic             mem_d_writeback_i,
  input  logic             mem_d_flush_i,
  output logic             mem_d_accept_o,
  output logic             mem_d_ack_o,
  output logic             mem_d_error_o,
  output logic [31:0]      mem_d_data_rd_o,
  output logic [TAG_W-1:0] mem_d_resp_tag_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_wr_o,
  output logic             mem_rd_o,
  output logic [3:0]       mem_wr_o,
  input  logic             mem_accept_i,
  input  logic             mem_ack_i,
  input  logic             mem_error_i,
  input  logic [31:0]      mem_data_rd_i,
  output logic [CNT_W-1:0] arb_i_grants_o,
  output logic [CNT_W-1:0] arb_d_grants_o,
  output logic [CNT_W-1:0] arb_i_wait_o
);

  import riscv_arb_pkg::*;

  arb_state_t       state;
  arb_state_t       state_next;
  arb_owner_t       owner;
  logic [TAG_W-1:0] tag_q;

  logic d_req;
  logic d_cmo;
  logic idle;
  logic gnt_i;
  logic gnt_d;
  logic gnt_cmo;
  logic rsp_fire;
  logic rsp_i;
  logic rsp_d;

  assign d_req = mem_d_rd_i | (|mem_d_wr_i);
  assign d_cmo = (mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i)
               & ~d_req;
  assign idle  = (state == ST_IDLE);

  riscv_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .idle   (idle),
    .i_req  (mem_i_rd_i),
    .d_req  (d_req),
    .cmo    (d_cmo),
    .gnt_i  (gnt_i),
    .gnt_d  (gnt_d),
    .gnt_cmo(gnt_cmo)
  );

  assign mem_i_accept_o = gnt_i;
  assign mem_d_accept_o = gnt_d | gnt_cmo;

  assign rsp_i = rsp_fire && (owner == OWN_I);
  assign rsp_d = rsp_fire && (owner == OWN_D);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state; an accept with a same-cycle ack skips WAIT.
  always_comb begin
    state_next = state;
    rsp_fire   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (gnt_i || gnt_d) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (mem_accept_i) begin
          if (mem_ack_i) begin
            state_next = ST_IDLE;
            rsp_fire   = 1'b1;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_ack_i) begin
          state_next = ST_IDLE;
          rsp_fire   = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Register the granted request onto the shared port; hold until accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_addr_o    <= '0;
      mem_data_wr_o <= '0;
      mem_rd_o      <= 1'b0;
      mem_wr_o      <= '0;
      owner         <= OWN_I;
      tag_q         <= '0;
    end else if (gnt_i) begin
      mem_addr_o    <= fetch_addr(mem_i_pc_i);
      mem_data_wr_o <= '0;
      mem_rd_o      <= 1'b1;
      mem_wr_o      <= '0;
      owner         <= OWN_I;
    end else if (gnt_d) begin
      mem_addr_o    <= mem_d_addr_i;
      mem_data_wr_o <= mem_d_data_wr_i;
      mem_rd_o      <= mem_d_rd_i;
      mem_wr_o      <= mem_d_wr_i;
      owner         <= OWN_D;
      tag_q         <= mem_d_req_tag_i;
    end else if ((state == ST_ISSUE) && mem_accept_i) begin
      mem_rd_o      <= 1'b0;
      mem_wr_o      <= '0;
    end
  end

  // One-cycle response pulse to the owner; local ack for maintenance ops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_i_valid_o    <= 1'b0;
      mem_i_error_o    <= 1'b0;
      mem_i_inst_o     <= '0;
      mem_d_ack_o      <= 1'b0;
      mem_d_error_o    <= 1'b0;
      mem_d_data_rd_o  <= '0;
      mem_d_resp_tag_o <= '0;
    end else begin
      mem_i_valid_o <= rsp_i;
      mem_i_error_o <= rsp_i && mem_error_i;
      mem_d_ack_o   <= rsp_d || gnt_cmo;
      mem_d_error_o <= rsp_d && mem_error_i;
      if (rsp_i) begin
        mem_i_inst_o <= mem_data_rd_i;
      end
      if (rsp_d) begin
        mem_d_data_rd_o  <= mem_data_rd_i;
        mem_d_resp_tag_o <= tag_q;
      end else if (gnt_cmo) begin
        mem_d_resp_tag_o <= mem_d_req_tag_i;
      end
    end
  end

  // Free-running telemetry counters, wrapping at 2^CNT_W.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arb_i_grants_o <= '0;
      arb_d_grants_o <= '0;
      arb_i_wait_o   <= '0;
    end else begin
      arb_i_grants_o <= arb_i_grants_o + CNT_W'(gnt_i);
      arb_d_grants_o <= arb_d_grants_o + CNT_W'(gnt_d);
      arb_i_wait_o   <= arb_i_wait_o
                      + CNT_W'(mem_i_rd_i && !mem_i_accept_o);
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed bench with a response scoreboard.
// A small memory model answers the shared port with programmable delays.
module tb_riscv_mem_arbiter;

  localparam int TAG_W = 11;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             mem_i_rd_i;
  logic [31:0]      mem_i_pc_i;
  logic             mem_i_accept_o;
  logic             mem_i_valid_o;
  logic             mem_i_error_o;
  logic [31:0]      mem_i_inst_o;
  logic [31:0]      mem_d_addr_i;
  logic [31:0]      mem_d_data_wr_i;
  logic             mem_d_rd_i;
  logic [3:0]       mem_d_wr_i;
  logic [TAG_W-1:0] mem_d_req_tag_i;
  logic             mem_d_invalidate_i;
  logic             mem_d_writeback_i;
  logic             mem_d_flush_i;
  logic             mem_d_accept_o;
  logic             mem_d_ack_o;
  logic             mem_d_error_o;
  logic [31:0]      mem_d_data_rd_o;
  logic [TAG_W-1:0] mem_d_resp_tag_o;
  logic [31:0]      mem_addr_o;
  logic [31:0]      mem_data_wr_o;
  logic             mem_rd_o;
  logic [3:0]       mem_wr_o;
  logic             mem_accept_i;
  logic             mem_ack_i;
  logic             mem_error_i;
  logic [31:0]      mem_data_rd_i;
  logic [CNT_W-1:0] arb_i_grants_o;
  logic [CNT_W-1:0] arb_d_grants_o;
  logic [CNT_W-1:0] arb_i_wait_o;

  riscv_mem_arbiter #(
    .STARVE_LIMIT(4),
    .TAG_W(TAG_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .mem_i_rd_i        (mem_i_rd_i),
    .mem_i_pc_i        (mem_i_pc_i),
    .mem_i_accept_o    (mem_i_accept_o),
    .mem_i_valid_o     (mem_i_valid_o),
    .mem_i_error_o     (mem_i_error_o),
    .mem_i_inst_o      (mem_i_inst_o),
    .mem_d_addr_i      (mem_d_addr_i),
    .mem_d_data_wr_i   (mem_d_data_wr_i),
    .mem_d_rd_i        (mem_d_rd_i),
    .mem_d_wr_i        (mem_d_wr_i),
    .mem_d_req_tag_i   (mem_d_req_tag_i),
    .mem_d_invalidate_i(mem_d_invalidate_i),
    .mem_d_writeback_i (mem_d_writeback_i),
    .mem_d_flush_i     (mem_d_flush_i),
    .mem_d_accept_o    (mem_d_accept_o),
    .mem_d_ack_o       (mem_d_ack_o),
    .mem_d_error_o     (mem_d_error_o),
    .mem_d_data_rd_o   (mem_d_data_rd_o),
    .mem_d_resp_tag_o  (mem_d_resp_tag_o),
    .mem_addr_o        (mem_addr_o),
    .mem_data_wr_o     (mem_data_wr_o),
    .mem_rd_o          (mem_rd_o),
    .mem_wr_o          (mem_wr_o),
    .mem_accept_i      (mem_accept_i),
    .mem_ack_i         (mem_ack_i),
    .mem_error_i       (mem_error_i),
    .mem_data_rd_i     (mem_data_rd_i),
    .arb_i_grants_o    (arb_i_grants_o),
    .arb_d_grants_o    (arb_d_grants_o),
    .arb_i_wait_o      (arb_i_wait_o)
  );

  typedef struct {
    bit               is_d;
    bit               chk_data;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    bit               err;
  } exp_t;

  exp_t sb[$];

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int resp_cnt  = 0;
  int resp_cyc  = 0;
  int acc_stall = 0;
  int ack_wait  = 1;
  int exp_ig    = 0;
  int exp_dg    = 0;
  bit port_seen = 0;
  bit mem_err_next = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a == 32'h0000_2000) ? 32'h0000_0013 : (a ^ 32'h5A5A_0F0F);
  endfunction

  task automatic push(input bit is_d, input bit chk, input logic [31:0] d,
                      input logic [TAG_W-1:0] t, input bit e);
    exp_t x;
    x.is_d = is_d;
    x.chk_data = chk;
    x.data = d;
    x.tag = t;
    x.err = e;
    sb.push_back(x);
  endtask

  // Memory model: accept after acc_stall cycles, ack ack_wait cycles later.
  initial begin
    int stall;
    int wcnt;
    bit pend;
    bit e;
    logic [31:0] a;
    stall = 0;
    wcnt = 0;
    pend = 0;
    e = 0;
    a = '0;
    mem_accept_i = 1'b0;
    mem_ack_i = 1'b0;
    mem_error_i = 1'b0;
    mem_data_rd_i = '0;
    forever begin
      @(negedge clk);
      mem_accept_i = 1'b0;
      mem_ack_i = 1'b0;
      mem_error_i = 1'b0;
      if (pend) begin
        if (wcnt > 1) begin
          wcnt--;
        end else begin
          mem_ack_i = 1'b1;
          mem_data_rd_i = mdata(a);
          mem_error_i = e;
          pend = 0;
        end
      end else if (rst_n && (mem_rd_o || mem_wr_o != 4'd0)) begin
        if (stall < acc_stall) begin
          stall++;
        end else begin
          mem_accept_i = 1'b1;
          pend = 1;
          wcnt = ack_wait;
          a = mem_addr_o;
          e = mem_err_next;
          stall = 0;
        end
      end
    end
  end

  // Response monitor: pop and compare each core-side response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mem_rd_o || mem_wr_o != 4'd0) port_seen = 1;
      if (mem_i_valid_o || mem_d_ack_o) begin
        resp_cnt++;
        resp_cyc = cyc;
        if (sb.size() == 0) begin
          check("spurious_rsp", {mem_i_valid_o, mem_d_ack_o}, 0);
        end else begin
          e = sb.pop_front();
          if (e.is_d) begin
            check("d_ack", {mem_i_valid_o, mem_d_ack_o}, 2'b01);
            check("d_tag", mem_d_resp_tag_o, e.tag);
            check("d_err", {mem_d_error_o, mem_i_error_o}, {e.err, 1'b0});
            if (e.chk_data) check("d_data", mem_d_data_rd_o, e.data);
          end else begin
            check("i_valid", {mem_i_valid_o, mem_d_ack_o}, 2'b10);
            check("i_err", {mem_i_error_o, mem_d_error_o}, {e.err, 1'b0});
            if (e.chk_data) check("i_inst", mem_i_inst_o, e.data);
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    mem_i_rd_i = 1'b0;
    mem_i_pc_i = '0;
    mem_d_addr_i = '0;
    mem_d_data_wr_i = '0;
    mem_d_rd_i = 1'b0;
    mem_d_wr_i = '0;
    mem_d_req_tag_i = '0;
    mem_d_invalidate_i = 1'b0;
    mem_d_writeback_i = 1'b0;
    mem_d_flush_i = 1'b0;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_port"},
          {mem_addr_o, mem_data_wr_o, mem_rd_o, mem_wr_o}, 0);
    check({pfx, "_rsp"},
          {mem_i_valid_o, mem_i_error_o, mem_i_inst_o, mem_d_ack_o,
           mem_d_error_o, mem_d_data_rd_o, mem_d_resp_tag_o}, 0);
    check({pfx, "_acc"}, {mem_i_accept_o, mem_d_accept_o}, 0);
    check({pfx, "_cnt"},
          {arb_i_grants_o, arb_d_grants_o, arb_i_wait_o}, 0);
  endtask

  // Called at a falling edge; returns the cycle the grant was shown.
  task automatic wait_grant(input bit want_d, output int gcyc);
    int n;
    n = 0;
    gcyc = cyc;
    forever begin
      #2;
      if (want_d ? mem_d_accept_o : mem_i_accept_o) begin
        gcyc = cyc;
        break;
      end
      if (n >= 40) begin
        check("grant_timeout", want_d ? mem_d_accept_o : mem_i_accept_o, 1);
        break;
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_resp(input int target);
    int n;
    n = 0;
    while (resp_cnt < target && n < 40) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("rsp_timeout", resp_cnt >= target, 1);
  endtask

  initial begin
    int g;
    int gd;
    int r0;
    logic [5:0] ord;
    int ngr;
    bit last_i;
    bit last_d;
    logic [31:0] a3;
    logic [TAG_W-1:0] t3;

    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: lone fetch, misaligned pc.
    @(negedge clk);
    mem_i_rd_i = 1'b1;
    mem_i_pc_i = 32'h0000_2003;
    wait_grant(0, g);
    push(0, 1, 32'h0000_0013, '0, 0);
    exp_ig++;
    @(negedge clk);
    mem_i_rd_i = 1'b0;
    #2;
    check("t1_addr", mem_addr_o, 32'h0000_2000);
    check("t1_rdwr", {mem_rd_o, mem_wr_o}, 5'b10000);
    wait_resp(1);
    check("t1_lat", resp_cyc - g, 3);
    check("t1_igr", arb_i_grants_o, exp_ig);

    // 2: simultaneous fetch and data read.
    @(negedge clk);
    mem_i_rd_i = 1'b1;
    mem_i_pc_i = 32'h0000_0100;
    mem_d_rd_i = 1'b1;
    mem_d_addr_i = 32'h8000_0010;
    mem_d_req_tag_i = 11'h5A5;
    #2;
    check("t2_first_d", {mem_d_accept_o, mem_i_accept_o}, 2'b10);
    gd = cyc;
    push(1, 1, mdata(32'h8000_0010), 11'h5A5, 0);
    exp_dg++;
    @(negedge clk);
    mem_d_rd_i = 1'b0;
    mem_d_addr_i = '0;
    mem_d_req_tag_i = '0;
    wait_grant(0, g);
    push(0, 1, mdata(32'h0000_0100), '0, 0);
    exp_ig++;
    check("t2_i_next", g - gd, 3);
    @(negedge clk);
    mem_i_rd_i = 1'b0;
    wait_resp(3);
    check("t2_iwait", arb_i_wait_o, 3);
    check("t2_dgr", arb_d_grants_o, exp_dg);
    check("t2_igr", arb_i_grants_o, exp_ig);

    // 3: continuous data with a fetch pending; fetch wins the 5th grant.
    @(negedge clk);
    a3 = 32'h8000_0040;
    t3 = 11'h010;
    mem_i_rd_i = 1'b1;
    mem_i_pc_i = 32'h0000_0300;
    mem_d_rd_i = 1'b1;
    mem_d_addr_i = a3;
    mem_d_req_tag_i = t3;
    ord = '0;
    ngr = 0;
    for (int k = 0; k < 80 && ngr < 6; k++) begin
      last_i = 0;
      last_d = 0;
      #2;
      if (mem_d_accept_o) begin
        ord = {ord[4:0], 1'b0};
        push(1, 1, mdata(a3), t3, 0);
        exp_dg++;
        ngr++;
        last_d = 1;
      end else if (mem_i_accept_o) begin
        ord = {ord[4:0], 1'b1};
        push(0, 1, mdata(32'h0000_0300), '0, 0);
        exp_ig++;
        ngr++;
        last_i = 1;
      end
      @(negedge clk);
      if (last_i) mem_i_rd_i = 1'b0;
      if (last_d) begin
        a3 = a3 + 32'd4;
        t3 = t3 + 11'd1;
        mem_d_addr_i = a3;
        mem_d_req_tag_i = t3;
      end
    end
    idle_inputs();
    check("t3_count", ngr, 6);
    check("t3_order", ord, 6'b000010);
    wait_resp(9);
    check("t3_igr", arb_i_grants_o, exp_ig);

    // 4: byte store held off by three cycles of backpressure.
    @(negedge clk);
    acc_stall = 3;
    mem_d_wr_i = 4'b0011;
    mem_d_addr_i = 32'h1000_0008;
    mem_d_data_wr_i = 32'hDEAD_BEEF;
    mem_d_req_tag_i = 11'h123;
    #2;
    check("t4_acc", mem_d_accept_o, 1);
    push(1, 0, '0, 11'h123, 0);
    exp_dg++;
    @(negedge clk);
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #2;
      check("t4_hold", {mem_addr_o, mem_data_wr_o, mem_rd_o, mem_wr_o},
            {32'h1000_0008, 32'hDEAD_BEEF, 1'b0, 4'b0011});
    end
    @(negedge clk);
    #2;
    check("t4_drop", {mem_rd_o, mem_wr_o}, 0);
    acc_stall = 0;
    wait_resp(10);
    check("t4_dgr", arb_d_grants_o, exp_dg);

    // 5: flush alone is acked locally.
    @(negedge clk);
    port_seen = 0;
    mem_d_flush_i = 1'b1;
    mem_d_req_tag_i = 11'h001;
    #2;
    check("t5_acc", {mem_d_accept_o, mem_i_accept_o}, 2'b10);
    g = cyc;
    push(1, 0, '0, 11'h001, 0);
    @(negedge clk);
    idle_inputs();
    wait_resp(11);
    check("t5_lat", resp_cyc - g, 1);
    repeat (2) @(negedge clk);
    #2;
    check("t5_noport", port_seen, 0);
    check("t5_dgr", arb_d_grants_o, exp_dg);

    // 6a: reset while waiting for an ack; the late ack must be dropped.
    @(negedge clk);
    ack_wait = 3;
    mem_i_rd_i = 1'b1;
    mem_i_pc_i = 32'h0000_2040;
    wait_grant(0, g);
    @(negedge clk);
    mem_i_rd_i = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero("t6_rst");
    @(negedge clk);
    #1 rst_n = 1'b1;
    r0 = resp_cnt;
    exp_ig = 0;
    exp_dg = 0;
    repeat (5) @(negedge clk);
    #3;
    check("t6_no_rsp", resp_cnt, r0);
    ack_wait = 1;

    // 6b: memory error on a fetch goes to the fetch side only.
    @(negedge clk);
    mem_err_next = 1;
    mem_i_rd_i = 1'b1;
    mem_i_pc_i = 32'h0000_2000;
    wait_grant(0, g);
    push(0, 1, 32'h0000_0013, '0, 1);
    exp_ig++;
    @(negedge clk);
    mem_i_rd_i = 1'b0;
    wait_resp(r0 + 1);
    mem_err_next = 0;
    check("t6_igr", arb_i_grants_o, exp_ig);

    repeat (4) @(negedge clk);
    #2;
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
Shares one memory port between the riscv_core instruction-fetch port (mem_i_*) and data port (mem_d_*). One transaction is outstanding at a time. Data requests have priority over instruction fetches, and a starvation guard bounds how long fetches can be locked out. The block also exports grant and wait counters alongside the core's tlm_* telemetry. It sits between riscv_core and the SoC memory/interconnect.

Parameters:
STARVE_LIMIT, 4, number of consecutive data grants after which a pending fetch wins the next arbitration.
TAG_W, 11, width of the data request/response tag.
CNT_W, 32, width of the telemetry counters.

Ports:
clk_i  in  1  clock; all state changes on the rising edge.
rst_ni  in  1  reset; asynchronous assertion, active-low.
mem_i_rd_i  in  1  fetch request.
mem_i_pc_i  in  32  fetch address.
mem_i_accept_o  out  1  fetch request taken.
mem_i_valid_o  out  1  fetch response valid.
mem_i_error_o  out  1  fetch response error.
mem_i_inst_o  out  32  fetched instruction.
mem_d_addr_i  in  32  data address.
mem_d_data_wr_i  in  32  write data.
mem_d_rd_i  in  1  data read request.
mem_d_wr_i  in  4  byte write strobes.
mem_d_req_tag_i  in  TAG_W  request tag.
mem_d_invalidate_i / mem_d_writeback_i / mem_d_flush_i  in  1 each  cache maintenance requests.
mem_d_accept_o  out  1  data request taken.
mem_d_ack_o  out  1  data response valid.
mem_d_error_o  out  1  data response error.
mem_d_data_rd_o  out  32  read data.
mem_d_resp_tag_o  out  TAG_W  response tag.
mem_addr_o  out  32  shared-port address (word-aligned for fetch).
mem_data_wr_o  out  32  shared-port write data.
mem_rd_o  out  1  shared-port read.
mem_wr_o  out  4  shared-port byte strobes.
mem_accept_i  in  1  shared port accepted the request.
mem_ack_i  in  1  shared-port response.
mem_error_i  in  1  shared-port error, qualified by mem_ack_i.
mem_data_rd_i  in  32  shared-port read data.
arb_i_grants_o  out  CNT_W  fetch grants.
arb_d_grants_o  out  CNT_W  data grants (rd/wr only).
arb_i_wait_o  out  CNT_W  cycles with a fetch pending but not accepted.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, owner=I, streak=0, counters 0. Reset asserted mid-transaction drops the transaction; no response is produced after release.
- FSM has three states: IDLE, ISSUE, WAIT.
- IDLE:
  - d_req = mem_d_rd_i | (|mem_d_wr_i).
  - d_cmo = invalidate | writeback | flush with no rd/wr.
  - Grant rule: data wins if d_req, unless mem_i_rd_i is pending and streak >= STARVE_LIMIT, in which case the fetch wins.
  - Grant is shown combinationally on the winner's *_accept_o in the same cycle. The request is registered into the mem_* outputs, owner is recorded, and the FSM goes to ISSUE.
  - For a fetch, mem_addr_o = {pc[31:2], 2'b00}, mem_rd_o=1, mem_wr_o=0.
  - A d_cmo with no competing d_req: mem_d_accept_o=1, then the next cycle mem_d_ack_o=1 with the same tag, error=0. No shared-port access; FSM stays in IDLE. A pending fetch has priority over a cmo.
- ISSUE: hold mem_* stable until mem_accept_i, then drop mem_rd_o/mem_wr_o and go to WAIT. If mem_accept_i and mem_ack_i arrive in the same cycle, treat it as ISSUE followed by ack and go directly to response.
- WAIT: on mem_ack_i, register the response. The cycle after the ack, pulse mem_i_valid_o or mem_d_ack_o for exactly 1 cycle with data, error and the stored tag. Return to IDLE in that same cycle, so the next grant is possible in the response cycle.
- Latency: request cycle N gives mem_rd_o/wr_o at N+1. mem_ack_i at cycle M gives the core response at M+1.
- Streak: +1 on each data grant (saturates at STARVE_LIMIT); cleared on a fetch grant or when no fetch is pending in IDLE.
- Counters: free-running and wrap modulo 2^CNT_W. arb_i_wait_o counts every cycle with mem_i_rd_i=1 and mem_i_accept_o=0.
- mem_error_i is forwarded only to the owner's error output.

Decomposition:
- Shared package riscv_arb_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT);
  - the owner enum (OWN_I/OWN_D);
  - the fetch-align mask constant.
- One sub-module, riscv_arb_prio: a combinational grant decision plus the streak counter register.

Test Plan:
1. Fetch only: mem_i_rd_i=1, pc=0x2003, memory accepts immediately and acks 2 cycles later with 0x00000013. Required: mem_addr_o=0x2000; mem_i_valid_o for 1 cycle with inst 0x13, 3 cycles after the request; arb_i_grants_o=1.
2. Simultaneous requests: mem_i_rd_i=1 and mem_d_rd_i=1 (addr 0x80000010, tag 0x5A5) in the same cycle. Required: data is granted first; resp_tag=0x5A5; the fetch is granted next; arb_i_wait_o counts the fetch wait.
3. Starvation: continuous data requests with a fetch pending, STARVE_LIMIT=4. Required: the 5th grant goes to the fetch; grant order D,D,D,D,I,D.
4. Store with backpressure: mem_d_wr_i=4'b0011, data 0xDEADBEEF; mem_accept_i held low for 3 cycles. Required: mem_* held stable all 4 cycles; after ack, mem_d_ack_o=1; arb_d_grants_o=1.
5. Cache maintenance: mem_d_flush_i alone, tag 0x001. Required: accept the same cycle; ack the next cycle with tag 0x001; mem_rd_o and mem_wr_o never asserted.
6. Reset while in WAIT, and a memory error: rst_ni pulsed low while in WAIT, then a late mem_ack_i. Required: all outputs 0 and no spurious valid/ack after release. Separately, mem_error_i=1 on a fetch ack gives mem_i_error_o=1 and mem_d_error_o=0.
